// File: rtl/mux_nto1_scan.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mux_nto1_scan                                                   |
// | Purpose  : Registered N:1 channel multiplexer with a manual-select mode    |
// |            and an automatic round-robin scan mode, presenting the chosen   |
// |            channel on a valid/ready output together with its index.        |
// | Ports    : clk, rst_n (async assert, active low)                           |
// |            in_data  - NUM_CH packed channels, channel k at [k*WIDTH+:WIDTH]|
// |            mode     - 0 manual select, 1 round-robin scan                  |
// |            sel      - manual channel select                                |
// |            ch_en    - scan enable mask, bit k enables channel k            |
// |            dwell    - cycles per scan slot (0 behaves as 1)                |
// |            out_data/out_ch/out_valid/out_ready - registered output stream  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mux_nto1_scan #(
  parameter int NUM_CH  = 16,
  parameter int WIDTH   = 8,
  parameter int SEL_W   = $clog2(NUM_CH),
  parameter int DWELL_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH*WIDTH-1:0]   in_data,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic [DWELL_W-1:0]        dwell,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_valid,
  input  logic                      out_ready
);

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_SEEK   = 2'd1,
    ST_DWELL  = 2'd2,
    ST_WAIT   = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [SEL_W-1:0]     ptr, ptr_nxt;
  logic [DWELL_W-1:0]   cnt, cnt_nxt;

  logic                 free;
  logic                 cap;
  logic [SEL_W-1:0]     cap_idx;
  logic                 sel_ok;
  logic                 any_en;
  logic [DWELL_W-1:0]   dwell_last;
  logic [SEL_W-1:0]     first_idx;
  logic [SEL_W-1:0]     next_idx;

  logic [WIDTH-1:0]     ch_arr [NUM_CH];

  // Unpack the flat input bus so the capture mux indexes by channel number.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign ch_arr[g] = in_data[g*WIDTH +: WIDTH];
  end

  // The output register can take a new item when empty or being drained.
  assign free   = !out_valid || out_ready;
  assign any_en = |ch_en;

  // Select values beyond the last channel (non power-of-two NUM_CH) never capture.
  assign sel_ok = {1'b0, sel} < (SEL_W+1)'(NUM_CH);

  // Terminal count of a slot: D-1 with a dwell of 0 behaving as 1.
  assign dwell_last = (dwell == '0) ? '0 : (dwell - DWELL_W'(1));

  // Lowest enabled channel, used when a scan (re)starts.
  always_comb begin : p_first
    first_idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (ch_en[SEL_W'(k)]) first_idx = SEL_W'(k);
    end
  end

  // Next enabled channel searching circularly from ptr+1. The final
  // iteration wraps back to ptr itself, so a lone enabled channel keeps ptr.
  always_comb begin : p_next
    int  j;
    logic found;
    next_idx = ptr;
    found    = 1'b0;
    j        = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (!found && ch_en[SEL_W'(j)]) begin
        next_idx = SEL_W'(j);
        found    = 1'b1;
      end
    end
  end

  always_comb begin : p_fsm
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    cap       = 1'b0;
    cap_idx   = ptr;
    case (state)
      ST_MANUAL: begin
        if (mode) begin
          state_nxt = ST_SEEK;
        end else if (free && sel_ok) begin
          cap     = 1'b1;
          cap_idx = sel;
        end
      end
      ST_SEEK: begin
        if (!mode) begin
          state_nxt = ST_MANUAL;
        end else if (any_en) begin
          ptr_nxt   = first_idx;
          cnt_nxt   = '0;
          state_nxt = ST_DWELL;
        end
      end
      ST_DWELL: begin
        if (!mode) begin
          state_nxt = ST_MANUAL;
        end else if (cnt < dwell_last) begin
          // '<' rather than '!=' so a dwell shortened below the running
          // count ends the slot at once instead of wrapping the counter.
          cnt_nxt = cnt + DWELL_W'(1);
        end else if (free) begin
          // A slot whose channel was disabled mid-dwell is skipped silently.
          cap     = ch_en[ptr];
          cnt_nxt = '0;
          if (any_en) ptr_nxt = next_idx;
          else        state_nxt = ST_SEEK;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!mode) begin
          state_nxt = ST_MANUAL;
        end else if (free) begin
          cap     = ch_en[ptr];
          cnt_nxt = '0;
          if (any_en) begin
            ptr_nxt   = next_idx;
            state_nxt = ST_DWELL;
          end else begin
            state_nxt = ST_SEEK;
          end
        end
      end
      default: state_nxt = ST_MANUAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_regs
    if (!rst_n) begin
      state     <= ST_MANUAL;
      ptr       <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      // A held item (valid and not ready) is never overwritten.
      if (free) begin
        out_valid <= cap;
        if (cap) begin
          out_data <= ch_arr[cap_idx];
          out_ch   <= cap_idx;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_nto1_scan.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mux_nto1_scan                                                |
// | Purpose  : Self-checking bench for mux_nto1_scan. Expected captures are    |
// |            queued with the cycle they must appear on and matched against   |
// |            every new item loaded into the output register.                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_mux_nto1_scan;

  localparam int NUM_CH  = 16;
  localparam int WIDTH   = 8;
  localparam int SEL_W   = 4;
  localparam int DWELL_W = 8;

  logic                    clk   = 1'b0;
  logic                    rst_n = 1'b1;
  logic [NUM_CH*WIDTH-1:0] in_data = '0;
  logic                    mode  = 1'b0;
  logic [SEL_W-1:0]        sel   = '0;
  logic [NUM_CH-1:0]       ch_en = '0;
  logic [DWELL_W-1:0]      dwell = '0;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_ch;
  logic                    out_valid;
  logic                    out_ready = 1'b1;

  // Second instance with a non power-of-two channel count, manual mode only.
  logic [WIDTH-1:0]        out_data12;
  logic [SEL_W-1:0]        out_ch12;
  logic                    out_valid12;
  logic                    mode12  = 1'b0;
  logic                    ready12 = 1'b1;
  logic [11:0]             ch_en12 = '0;

  mux_nto1_scan #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DWELL_W(DWELL_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .mode(mode), .sel(sel),
    .ch_en(ch_en), .dwell(dwell), .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_nto1_scan #(.NUM_CH(12), .WIDTH(WIDTH), .DWELL_W(DWELL_W)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[12*WIDTH-1:0]), .mode(mode12), .sel(sel),
    .ch_en(ch_en12), .dwell(dwell), .out_data(out_data12), .out_ch(out_ch12),
    .out_valid(out_valid12), .out_ready(ready12)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SEL_W-1:0] ch;
    logic [WIDTH-1:0] data;
    int               cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic sb_on    = 1'b0;

  task automatic push_exp(input int ch, input logic [WIDTH-1:0] data, input int c);
    exp_t e;
    e.ch   = SEL_W'(ch);
    e.data = data;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic set_data(input logic [WIDTH-1:0] b);
    for (int k = 0; k < NUM_CH; k++) in_data[k*WIDTH +: WIDTH] = b + WIDTH'(k);
  endtask

  // One clock; afterwards any newly loaded output item is matched against
  // the head of the scoreboard, and overdue expectations are reported.
  task automatic tick();
    logic free_prev;
    exp_t e;
    free_prev = !out_valid || out_ready;
    @(posedge clk);
    cyc++;
    #1;
    if (sb_on && free_prev && out_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_capture: cyc=%0d got ch=%0d data=%h, required no capture",
                 cyc, out_ch, out_data);
      end else begin
        e = exp_q.pop_front();
        if (out_ch !== e.ch || out_data !== e.data || cyc !== e.cyc)
          $display("FAIL capture: got ch=%0d data=%h cyc=%0d, required ch=%0d data=%h cyc=%0d",
                   out_ch, out_data, cyc, e.ch, e.data, e.cyc);
        else
          n_pass++;
      end
    end
    while (sb_on && exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      n_checks++;
      $display("FAIL missed_capture: cyc=%0d got nothing, required ch=%0d data=%h at cyc=%0d",
               cyc, e.ch, e.data, e.cyc);
    end
  endtask

  task automatic drain_check(input string name);
    n_checks++;
    if (exp_q.size() != 0)
      $display("FAIL %s_leftover: got %0d pending expectations, required 0", name, exp_q.size());
    else
      n_pass++;
    exp_q.delete();
    sb_on = 1'b0;
  endtask

  task automatic do_reset();
    sb_on     = 1'b0;
    mode      = 1'b0;
    sel       = '0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || out_ch !== '0 || out_data !== '0)
      $display("FAIL reset16: got v=%b ch=%0d d=%h, required 0/0/00", out_valid, out_ch, out_data);
    else n_pass++;
    n_checks++;
    if (out_valid12 !== 1'b0 || out_ch12 !== '0 || out_data12 !== '0)
      $display("FAIL reset12: got v=%b ch=%0d d=%h, required 0/0/00",
               out_valid12, out_ch12, out_data12);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_manual();
    do_reset();
    set_data(8'h10);
    sb_on = 1'b1;
    for (int s = 0; s < NUM_CH; s++) begin
      sel = SEL_W'(s);
      push_exp(s, 8'h10 + WIDTH'(s), cyc + 1);
      tick();
    end
    sel = 4'd13;
    push_exp(13, 8'h1D, cyc + 1);
    tick();
    n_checks++;
    if (out_valid12 !== 1'b0)
      $display("FAIL manual_sel_oob12: got out_valid=%b, required 0", out_valid12);
    else n_pass++;
    sel = 4'd5;
    push_exp(5, 8'h15, cyc + 1);
    tick();
    n_checks++;
    if (out_valid12 !== 1'b1 || out_ch12 !== 4'd5 || out_data12 !== 8'h15)
      $display("FAIL manual_sel12: got v=%b ch=%0d d=%h, required 1/5/15",
               out_valid12, out_ch12, out_data12);
    else n_pass++;
    drain_check("manual");
  endtask

  task automatic test_scan();
    int base;
    do_reset();
    set_data(8'hA0);
    ch_en = 16'h00A5;
    dwell = 8'd3;
    mode  = 1'b1;
    base  = cyc;
    sb_on = 1'b1;
    push_exp(0, 8'hA0, base + 5);
    push_exp(2, 8'hA2, base + 8);
    push_exp(5, 8'hA5, base + 11);
    push_exp(7, 8'hA7, base + 14);
    push_exp(0, 8'hA0, base + 17);
    push_exp(2, 8'hA2, base + 20);
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (out_valid !== 1'b0)
      $display("FAIL scan_entry_early: got out_valid=%b 4 edges after mode, required 0", out_valid);
    else n_pass++;
    tick();
    n_checks++;
    if (out_valid !== 1'b1)
      $display("FAIL scan_entry: got out_valid=%b 5 edges after mode, required 1", out_valid);
    else n_pass++;
    for (int i = 0; i < 15; i++) tick();
    drain_check("scan");
  endtask

  task automatic test_backpressure();
    int base;
    do_reset();
    set_data(8'hB0);
    ch_en = 16'h00A5;
    dwell = 8'd2;
    mode  = 1'b1;
    base  = cyc;
    sb_on = 1'b1;
    push_exp(0, 8'hB0, base + 4);
    push_exp(2, 8'hB2, base + 6);
    push_exp(5, 8'hB5, base + 8);
    push_exp(7, 8'hB7, base + 19);
    push_exp(0, 8'hB0, base + 21);
    for (int i = 0; i < 8; i++) tick();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_ch !== 4'd5 || out_data !== 8'hB5)
        $display("FAIL bp_hold: cyc=%0d got v=%b ch=%0d d=%h, required 1/5/b5",
                 cyc, out_valid, out_ch, out_data);
      else n_pass++;
    end
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    drain_check("backpressure");
  endtask

  task automatic test_masks();
    int base;
    // Empty mask: scan sits in SEEK and never captures until a bit appears.
    do_reset();
    set_data(8'h50);
    ch_en = '0;
    dwell = 8'd1;
    mode  = 1'b1;
    sb_on = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    n_checks++;
    if (out_valid !== 1'b0)
      $display("FAIL mask_empty: got out_valid=%b, required 0", out_valid);
    else n_pass++;
    ch_en = 16'h0010;
    base  = cyc;
    push_exp(4, 8'h54, base + 2);
    tick();
    tick();
    drain_check("mask_empty");

    // Single enabled channel with dwell 0: same channel every cycle.
    do_reset();
    set_data(8'h60);
    ch_en = 16'h0100;
    dwell = 8'd0;
    mode  = 1'b1;
    base  = cyc;
    sb_on = 1'b1;
    for (int c = 3; c <= 8; c++) push_exp(8, 8'h68, base + c);
    for (int i = 0; i < 8; i++) tick();
    drain_check("mask_single");

    // Channel 2 disabled while its slot is dwelling: slot skipped, no capture.
    do_reset();
    set_data(8'h70);
    ch_en = 16'h00A5;
    dwell = 8'd4;
    mode  = 1'b1;
    base  = cyc;
    sb_on = 1'b1;
    push_exp(0, 8'h70, base + 6);
    push_exp(5, 8'h75, base + 14);
    push_exp(7, 8'h77, base + 18);
    for (int i = 0; i < 7; i++) tick();
    ch_en = 16'h00A1;
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if (out_valid !== 1'b0)
      $display("FAIL mask_skip: got out_valid=%b at skipped slot, required 0", out_valid);
    else n_pass++;
    for (int i = 0; i < 8; i++) tick();
    drain_check("mask_skip");
  endtask

  task automatic test_mode_switch();
    int base;
    do_reset();
    set_data(8'h30);
    ch_en = 16'h00A5;
    dwell = 8'd3;
    mode  = 1'b1;
    base  = cyc;
    sb_on = 1'b1;
    push_exp(0, 8'h30, base + 5);
    push_exp(3, 8'h33, base + 9);
    push_exp(3, 8'h43, base + 10);
    for (int i = 0; i < 5; i++) tick();
    out_ready = 1'b0;
    tick();
    mode = 1'b0;
    sel  = 4'd3;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_ch !== 4'd0 || out_data !== 8'h30)
        $display("FAIL mode_pending: cyc=%0d got v=%b ch=%0d d=%h, required 1/0/30",
                 cyc, out_valid, out_ch, out_data);
      else n_pass++;
    end
    out_ready = 1'b1;
    tick();
    set_data(8'h40);
    tick();
    drain_check("mode_switch");
  endtask

  task automatic test_reset_mid_scan();
    int base;
    do_reset();
    set_data(8'hC0);
    ch_en = 16'h00A5;
    dwell = 8'd1;
    mode  = 1'b1;
    base  = cyc;
    sb_on = 1'b1;
    push_exp(0, 8'hC0, base + 3);
    push_exp(2, 8'hC2, base + 4);
    for (int i = 0; i < 4; i++) tick();
    out_ready = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_ch !== 4'd2)
      $display("FAIL rst_mid_pre: got v=%b ch=%0d, required 1/2", out_valid, out_ch);
    else n_pass++;
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_ch !== '0 || out_data !== '0)
      $display("FAIL rst_mid_async: got v=%b ch=%0d d=%h, required 0/0/00",
               out_valid, out_ch, out_data);
    else n_pass++;
    tick();
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    base      = cyc;
    // mode is still high: MANUAL -> SEEK -> DWELL(ptr 0) -> capture.
    push_exp(0, 8'hC0, base + 3);
    for (int i = 0; i < 3; i++) tick();
    drain_check("reset_mid_scan");
  endtask

  initial begin
    test_reset();
    test_manual();
    test_scan();
    test_backpressure();
    test_masks();
    test_mode_switch();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
